// File: rtl/systolic_conv_engine.sv
// Valid-mode 2-D correlation of an IMG x IMG image with a KER x KER kernel.
// One kernel tap is broadcast per cycle to OUT x OUT accumulators; results then stream out row-major.
module systolic_conv_engine #(
    parameter int DW    = 8,
    parameter int IMG   = 4,
    parameter int KER   = 3,
    parameter int ACC_W = 20,
    localparam int OUT  = IMG - KER + 1,
    localparam int OW   = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    signed_mode,
    input  logic [IMG*IMG*DW-1:0]   img_flat,
    input  logic [KER*KER*DW-1:0]   ker_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [OW-1:0]           out_row,
    output logic [OW-1:0]           out_col,
    output logic                    out_last
);

    localparam int NPE  = OUT * OUT;
    localparam int NTAP = KER * KER;
    localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAP - 1);
    localparam logic [OW-1:0] LAST_IDX = OW'(OUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]              state;
    logic [IMG*IMG*DW-1:0]   img_r;
    logic [KER*KER*DW-1:0]   ker_r;
    logic                    sgn_r;
    logic [TW-1:0]           tap;
    logic [ACC_W-1:0]        acc      [NPE];
    logic [ACC_W-1:0]        img_ext  [NPE];
    logic [ACC_W-1:0]        tap_prod [NPE];
    logic [ACC_W-1:0]        ker_ext;

    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v, input logic s);
        return {{(ACC_W-DW){s & v[DW-1]}}, v};
    endfunction

    always_comb begin
        ker_ext = '0;
        for (int unsigned t = 0; t < NTAP; t++) begin
            if (tap == TW'(t)) ker_ext = ext(ker_r[t*DW +: DW], sgn_r);
        end
    end

    // Tap selection compares against constant tap numbers so every image slice index is static.
    always_comb begin
        for (int unsigned r = 0; r < OUT; r++) begin
            for (int unsigned c = 0; c < OUT; c++) begin
                img_ext[r*OUT+c] = '0;
                for (int unsigned ki = 0; ki < KER; ki++) begin
                    for (int unsigned kj = 0; kj < KER; kj++) begin
                        if (tap == TW'(ki*KER + kj))
                            img_ext[r*OUT+c] = ext(img_r[((r+ki)*IMG + c + kj)*DW +: DW], sgn_r);
                    end
                end
                tap_prod[r*OUT+c] = img_ext[r*OUT+c] * ker_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tap     <= '0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_r   <= img_flat;
                        ker_r   <= ker_flat;
                        sgn_r   <= signed_mode;
                        tap     <= '0;
                        out_row <= '0;
                        out_col <= '0;
                        for (int unsigned p = 0; p < NPE; p++) acc[p] <= '0;
                        state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    for (int unsigned p = 0; p < NPE; p++) acc[p] <= acc[p] + tap_prod[p];
                    if (tap == LAST_TAP) begin
                        tap   <= '0;
                        state <= S_OUTPUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (out_row == LAST_IDX && out_col == LAST_IDX) begin
                            out_row <= '0;
                            out_col <= '0;
                            state   <= S_DONE;
                        end else if (out_col == LAST_IDX) begin
                            out_col <= '0;
                            out_row <= out_row + 1'b1;
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == S_COMPUTE) || (state == S_OUTPUT);
        done      = (state == S_DONE);
        out_valid = (state == S_OUTPUT);
        out_last  = out_valid && (out_row == LAST_IDX) && (out_col == LAST_IDX);
        out_data  = '0;
        if (out_valid) begin
            for (int unsigned r = 0; r < OUT; r++) begin
                for (int unsigned c = 0; c < OUT; c++) begin
                    if (out_row == OW'(r) && out_col == OW'(c)) out_data = acc[r*OUT+c];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_conv_engine.sv
// Scoreboard bench for systolic_conv_engine: stimulus pushes expected results, a monitor pops them
// on each accepted transfer; a second instance covers a non-default geometry.
module tb_systolic_conv_engine;

    localparam int DW = 8, IMG = 4, KER = 3, ACC_W = 20, OUT = 2, OW = 1;
    localparam int IW = IMG*IMG*DW, KW = KER*KER*DW;
    localparam int IMG2 = 5, KER2 = 2, ACC2 = 18;

    logic              clk = 1'b0;
    logic              rst, start, signed_mode, out_ready;
    logic [IW-1:0]     img_flat;
    logic [KW-1:0]     ker_flat;
    logic              busy, done, out_valid, out_last;
    logic [ACC_W-1:0]  out_data;
    logic [OW-1:0]     out_row, out_col;

    logic                    start_b, signed_mode_b, out_ready_b;
    logic [IMG2*IMG2*DW-1:0] img_flat_b;
    logic [KER2*KER2*DW-1:0] ker_flat_b;
    logic                    busy_b, done_b, out_valid_b, out_last_b;
    logic [ACC2-1:0]         out_data_b;
    logic [1:0]              out_row_b, out_col_b;

    systolic_conv_engine #(.DW(DW), .IMG(IMG), .KER(KER), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .img_flat(img_flat), .ker_flat(ker_flat), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    systolic_conv_engine #(.DW(8), .IMG(IMG2), .KER(KER2), .ACC_W(ACC2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(signed_mode_b),
        .img_flat(img_flat_b), .ker_flat(ker_flat_b), .busy(busy_b), .done(done_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_row(out_row_b), .out_col(out_col_b), .out_last(out_last_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [OW-1:0]    row;
        logic [OW-1:0]    col;
        logic             last;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0, checks = 0;
    longint cyc = 0, last_xfer_cyc = -1;
    int     n_done = 0, jobs_done = 0, rdy_mode = 0;
    logic [IW-1:0] img1;
    logic [KW-1:0] ker1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint elem(input logic [DW-1:0] x, input logic sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic logic [ACC_W-1:0] ref_conv(input logic [IW-1:0] img, input logic [KW-1:0] ker,
                                                  input logic sgn, input int r, input int c);
        longint s = 0;
        for (int i = 0; i < KER; i++)
            for (int j = 0; j < KER; j++)
                s += elem(img[((r+i)*IMG + c + j)*DW +: DW], sgn) * elem(ker[(i*KER + j)*DW +: DW], sgn);
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [IW-1:0] rand_img();
        logic [IW-1:0] v;
        for (int i = 0; i < IMG*IMG; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [KW-1:0] rand_ker();
        logic [KW-1:0] v;
        for (int i = 0; i < KER*KER; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic push_exp(input logic [ACC_W-1:0] d, input int r, input int c);
        exp_t e;
        e.data = d; e.row = OW'(r); e.col = OW'(c);
        e.last = (r == OUT-1) && (c == OUT-1);
        sb.push_back(e);
    endtask

    task automatic push_test1();
        push_exp(20'd348, 0, 0); push_exp(20'd393, 0, 1);
        push_exp(20'd528, 1, 0); push_exp(20'd573, 1, 1);
    endtask

    // Monitor: pops one expectation per accepted transfer and checks stability while stalled.
    initial begin
        exp_t e;
        logic held = 1'b0;
        logic [ACC_W-1:0] hd;
        logic [2*OW:0] hp;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (held) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    check("stall_data", 64'(out_data), 64'(hd));
                    check("stall_pos", 64'({out_row, out_col, out_last}), 64'(hp));
                end
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got data %0d, expected no output", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_pos", 64'({out_row, out_col}), 64'({e.row, e.col}));
                        check("out_last", 64'(out_last), 64'(e.last));
                        if (out_last) last_xfer_cyc = cyc;
                    end
                end else begin
                    held = 1'b1;
                    hd = out_data;
                    hp = {out_row, out_col, out_last};
                end
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = five stalled cycles after first valid then toggle.
    initial begin
        int bp = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!out_valid) begin
                        bp = 0; out_ready = 1'b0;
                    end else begin
                        bp++;
                        out_ready = (bp > 5) ? ~out_ready : 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic run_job(input logic [IW-1:0] img, input logic [KW-1:0] ker, input logic sgn,
                           input bit use_model, input bit pulse_ignored);
        longint lat;
        int n;
        if (use_model)
            for (int r = 0; r < OUT; r++)
                for (int c = 0; c < OUT; c++) push_exp(ref_conv(img, ker, sgn, r, c), r, c);
        img_flat = img; ker_flat = ker; signed_mode = sgn; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        img_flat = rand_img(); ker_flat = rand_ker(); signed_mode = ~sgn;
        check("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (pulse_ignored && lat == 3) begin
                start = 1'b1; img_flat = rand_img();
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("first_valid_latency", 64'(lat), 64'(KER*KER));
        if (pulse_ignored) begin
            start = 1'b1; ker_flat = rand_ker();
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("done_after_last", 64'(cyc), 64'(last_xfer_cyc + 1));
        check("busy_in_done", 64'(busy), 64'd0);
        check("valid_in_done", 64'(out_valid), 64'd0);
        if (pulse_ignored) begin
            start = 1'b1; img_flat = rand_img();
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_width", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        jobs_done++;
    endtask

    task automatic run_sweep();
        longint lat;
        int n, last_at;
        logic [1:0] er, ec;
        img_flat_b = '1; ker_flat_b = '0;
        for (int i = 0; i < IMG2*IMG2; i++) img_flat_b[i*8 +: 8] = 8'd1;
        for (int i = 0; i < KER2*KER2; i++) ker_flat_b[i*8 +: 8] = 8'd1;
        signed_mode_b = 1'b0; out_ready_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("sweep_latency", 64'(lat), 64'(KER2*KER2));
        n = 0; last_at = -1; er = '0; ec = '0;
        while (out_valid_b && n < 40) begin
            check("sweep_data", 64'(out_data_b), 64'd4);
            check("sweep_pos", 64'({out_row_b, out_col_b}), 64'({er, ec}));
            if (out_last_b) last_at = n;
            n++;
            if (ec == 2'd3) begin ec = '0; er = er + 1'b1; end
            else ec = ec + 1'b1;
            @(posedge clk); #1;
        end
        check("sweep_count", 64'(n), 64'd16);
        check("sweep_last_index", 64'(last_at), 64'd15);
        check("sweep_done", 64'(done_b), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; img_flat = '0; ker_flat = '0;
        start_b = 1'b0; signed_mode_b = 1'b0; out_ready_b = 1'b1; img_flat_b = '0; ker_flat_b = '0;
        for (int i = 0; i < IMG*IMG; i++) img1[i*DW +: DW] = DW'(i + 1);
        for (int i = 0; i < KER*KER; i++) ker1[i*DW +: DW] = DW'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_row", 64'(out_row), 64'd0);
        check("rst_col", 64'(out_col), 64'd0);
        check("rst_valid_b", 64'(out_valid_b), 64'd0);
        rst = 1'b0;

        push_test1();
        run_job(img1, ker1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) push_exp(20'hFFFEE, k / 2, k % 2);
        run_job('1, {KER*KER{8'h02}}, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(20'h011EE, k / 2, k % 2);
        run_job('1, {KER*KER{8'h02}}, 1'b0, 1'b0, 1'b0);

        rdy_mode = 2;
        push_test1();
        run_job(img1, ker1, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;
        @(posedge clk); #1;

        img_flat = rand_img(); ker_flat = rand_ker(); signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        push_test1();
        run_job(img1, ker1, 1'b0, 1'b0, 1'b0);

        push_test1();
        run_job(img1, ker1, 1'b0, 1'b0, 1'b1);

        rdy_mode = 1;
        for (int k = 0; k < 4; k++) run_job(rand_img(), rand_ker(), 1'(k), 1'b1, 1'b0);
        rdy_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("done_count", 64'(n_done), 64'(jobs_done));

        run_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
